// File: rtl/alu_op_sequencer.sv
// Command FIFO + settle/capture sequencer driving the 4-bit board ALU.
// Optional `ALU_SEQ_CHAIN_EN: chained commands take X from the last captured F.
module alu_op_sequencer #(
  parameter int FIFO_DEPTH    = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_x,
  input  logic [3:0] cmd_y,
  input  logic [1:0] cmd_op,
  input  logic       cmd_m0,
  input  logic       cmd_chain,
  output logic [3:0] alu_x,
  output logic [3:0] alu_y,
  output logic [1:0] alu_s,
  output logic       alu_m0,
  input  logic [3:0] alu_f,
  input  logic [3:0] alu_flags,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_f,
  output logic [3:0] rsp_flags,
  output logic [7:0] rsp_tag,
  output logic [7:0] op_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
`ifdef ALU_SEQ_CHAIN_EN
  localparam int EW = 12;
`else
  localparam int EW = 11;
`endif

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [EW-1:0] entry_in;
  logic [EW-1:0] head;
  logic [3:0]    ld_x;
  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          hs;

  assign full      = (count == (AW+1)'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && !full;
  assign hs        = (state == RESP) && rsp_valid && rsp_ready;
  assign pop       = !empty && ((state == IDLE) || hs);
  assign head      = mem[rd_ptr];

`ifdef ALU_SEQ_CHAIN_EN
  assign entry_in = {cmd_chain, cmd_m0, cmd_op, cmd_y, cmd_x};
  assign ld_x     = head[11] ? rsp_f : head[3:0];
`else
  logic chain_unused;
  assign chain_unused = cmd_chain;
  assign entry_in = {cmd_m0, cmd_op, cmd_y, cmd_x};
  assign ld_x     = head[3:0];
`endif

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= entry_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      alu_x     <= '0;
      alu_y     <= '0;
      alu_s     <= '0;
      alu_m0    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_f     <= '0;
      rsp_flags <= '0;
      rsp_tag   <= '0;
      op_count  <= '0;
    end else begin
      // Every pop starts a new settle window on fresh ALU inputs.
      if (pop) begin
        alu_x  <= ld_x;
        alu_y  <= head[7:4];
        alu_s  <= head[9:8];
        alu_m0 <= head[10];
        cnt    <= '0;
      end
      unique case (state)
        IDLE: if (pop) state <= WAIT;
        WAIT: begin
          if (cnt == CW'(SETTLE_CYCLES - 1)) begin
            rsp_f     <= alu_f;
            rsp_flags <= alu_flags;
            rsp_tag   <= op_count;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (hs) begin
            rsp_valid <= 1'b0;
            op_count  <= op_count + 1'b1;
            state     <= pop ? WAIT : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: ALU stand-in, in-order scoreboard, directed cases.
// Chain expectations follow `ALU_SEQ_CHAIN_EN when defined.
module tb_alu_op_sequencer;

  localparam int DEPTH = 4;
  localparam int S     = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_x = '0;
  logic [3:0] cmd_y = '0;
  logic [1:0] cmd_op = '0;
  logic       cmd_m0 = 1'b0;
  logic       cmd_chain = 1'b0;
  logic [3:0] alu_x, alu_y;
  logic [1:0] alu_s;
  logic       alu_m0;
  logic [3:0] alu_f, alu_flags;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [3:0] rsp_f, rsp_flags;
  logic [7:0] rsp_tag, op_count;

  alu_op_sequencer #(.FIFO_DEPTH(DEPTH), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_op(cmd_op),
    .cmd_m0(cmd_m0), .cmd_chain(cmd_chain),
    .alu_x(alu_x), .alu_y(alu_y), .alu_s(alu_s), .alu_m0(alu_m0),
    .alu_f(alu_f), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_f(rsp_f), .rsp_flags(rsp_flags),
    .rsp_tag(rsp_tag), .op_count(op_count)
  );

  always #50 clk = ~clk;

  // Returns {sign, zero, overflow, carry, F}; carry is no-borrow-inverted on subtract.
  function automatic logic [7:0] alu_ref(input logic [3:0] x, input logic [3:0] y,
                                         input logic [1:0] op, input logic m0);
    logic [4:0] s;
    logic [3:0] f, yy;
    logic v, c;
    v = 1'b0;
    c = 1'b0;
    yy = m0 ? ~y : y;
    s = {1'b0, x} + {1'b0, yy} + {4'b0, m0};
    case (op)
      2'b00: begin
        f = s[3:0];
        c = s[4] ^ m0;
        v = (x[3] == yy[3]) && (f[3] != x[3]);
      end
      2'b01: f = x & y;
      2'b10: f = x | y;
      default: f = x ^ y;
    endcase
    return {f[3], f == 4'd0, v, c, f};
  endfunction

  always_comb {alu_flags, alu_f} = alu_ref(alu_x, alu_y, alu_s, alu_m0);

  int checks = 0;
  int failures = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  logic [7:0] q[$];
  int         outst = 0;
  logic [7:0] mcount = '0;
  logic [3:0] mlast = '0;
  logic [3:0] last_f = '0, last_flags = '0;
  logic [7:0] last_tag = '0;
  int         cyc = 0;
  int         acc_edge = 0;
  int         rise_cyc = 0;
  logic       prev_rv = 1'b0;
  logic       hold_prev = 1'b0;
  logic [15:0] prev_rsp = '0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin : sampler
    logic [3:0] xx;
    logic [7:0] r;
    if (!rst_n) begin
      q.delete();
      outst = 0;
      mcount = '0;
      mlast = '0;
      prev_rv = 1'b0;
      hold_prev = 1'b0;
    end else begin
      chk("op_count", op_count, mcount);
      chk("cmd_ready", cmd_ready, outst <= DEPTH);
      if (hold_prev)
        chk("rsp_hold", {rsp_valid, rsp_f, rsp_flags, rsp_tag}, {1'b1, prev_rsp});
      if (rsp_valid && !prev_rv) rise_cyc = cyc;
      if (cmd_valid && cmd_ready) begin
`ifdef ALU_SEQ_CHAIN_EN
        xx = cmd_chain ? mlast : cmd_x;
`else
        xx = cmd_x;
`endif
        r = alu_ref(xx, cmd_y, cmd_op, cmd_m0);
        q.push_back(r);
        mlast = r[3:0];
        outst++;
        acc_edge = cyc + 1;
      end
      if (rsp_valid && rsp_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_rsp", 1, 0);
        end else begin
          r = q.pop_front();
          chk("rsp_f", rsp_f, r[3:0]);
          chk("rsp_flags", rsp_flags, r[7:4]);
          chk("rsp_tag", rsp_tag, mcount);
        end
        last_f = rsp_f;
        last_flags = rsp_flags;
        last_tag = rsp_tag;
        mcount++;
        outst--;
      end
      prev_rv = rsp_valid;
      hold_prev = rsp_valid && !rsp_ready;
      prev_rsp = {rsp_f, rsp_flags, rsp_tag};
    end
  end

  task automatic apply_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic send(input logic [3:0] x, input logic [3:0] y,
                      input logic [1:0] op, input logic m0, input logic ch);
    int n;
    n = 0;
    @(posedge clk);
    #1;
    cmd_x = x; cmd_y = y; cmd_op = op; cmd_m0 = m0; cmd_chain = ch;
    cmd_valid = 1'b1;
    @(negedge clk);
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk("send_timeout", 1, 0);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((outst != 0 || rsp_valid) && n < 500) begin
      @(posedge clk);
      n++;
    end
    if (n >= 500) chk("drain_timeout", 1, 0);
    #1;
  endtask

  int acc;

  initial begin
    apply_reset();
    chk("reset_cmd_ready", cmd_ready, 1);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_op_count", op_count, 0);

    send(4'd5, 4'd3, 2'b00, 1'b0, 1'b0);
    drain();
    chk("add_f", last_f, 4'h8);
    chk("add_flags", last_flags, 4'b1010);
    chk("add_tag", last_tag, 0);
    chk("add_latency", rise_cyc - acc_edge, S + 1);

    apply_reset();
    send(4'd3, 4'd3, 2'b00, 1'b1, 1'b0);
    drain();
    chk("sub_f", last_f, 4'h0);
    chk("sub_flags", last_flags, 4'b0100);
    send(4'hA, 4'h5, 2'b11, 1'b0, 1'b0);
    drain();
    chk("xor_f", last_f, 4'hF);
    chk("xor_flags", last_flags, 4'b1000);
    chk("xor_tag", last_tag, 1);

    apply_reset();
    rsp_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      cmd_x = 4'(i); cmd_y = 4'd1; cmd_op = 2'b00; cmd_m0 = 1'b0; cmd_chain = 1'b0;
      cmd_valid = 1'b1;
      @(negedge clk);
      if (cmd_ready) acc++;
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    chk("bp_accepts", acc, DEPTH + 1);
    chk("bp_cmd_ready", cmd_ready, 0);
    rsp_ready = 1'b1;
    drain();
    chk("bp_op_count", op_count, 5);
    chk("bp_last_f", last_f, 4'd5);

    apply_reset();
    send(4'd1, 4'd1, 2'b00, 1'b0, 1'b0);
    drain();
    chk("chain_first", last_f, 4'd2);
    send(4'd7, 4'd1, 2'b00, 1'b0, 1'b1);
    drain();
`ifdef ALU_SEQ_CHAIN_EN
    chk("chain_second", last_f, 4'd3);
`else
    chk("chain_second", last_f, 4'd8);
`endif

    apply_reset();
    @(posedge clk);
    #1;
    cmd_x = 4'd9; cmd_y = 4'd2; cmd_op = 2'b10; cmd_m0 = 1'b0; cmd_chain = 1'b0;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_x = 4'd6; cmd_y = 4'd6;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    chk("mid_alu_x_loaded", alu_x, 4'd9);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_alu", {alu_x, alu_y, alu_s, alu_m0}, 0);
    chk("rst_rsp", {rsp_valid, rsp_f, rsp_flags, rsp_tag}, 0);
    chk("rst_op_count", op_count, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid) chk("post_rst_rsp", rsp_valid, 0);
    end
    chk("post_rst_count", op_count, 0);

    apply_reset();
    for (int i = 0; i < 256; i++)
      send(4'(i), 4'(i >> 4), 2'(i), 1'(i >> 2), 1'b0);
    drain();
    chk("wrap_op_count", op_count, 0);
    chk("wrap_last_tag", last_tag, 8'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

- Command-side initiator for the 4-bit ALU on the virtual board.
- Buffers operation commands in a small FIFO and drives the ALU operand and control inputs one command at a time.
- Waits a fixed settle time, captures the ALU result and flags, and returns them on a valid/ready response channel with a sequence tag.
- Sits between a switch/push-button command front end (or a bench) and the combinational ALU.

## Interface
- FIFO_DEPTH, 4, command FIFO entries; power of two, ≥2
- SETTLE_CYCLES, 1, cycles the ALU inputs are held before capture; ≥1
- CLOCK  in  1  system clock, 10 MHz, rising edge
- RESET_N  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO not full
- cmd_x  in  4  operand X
- cmd_y  in  4  operand Y
- cmd_op  in  2  {S1,S0}: 00 add/sub, 01 AND, 10 OR, 11 XOR
- cmd_m0  in  1  M0: 1 selects subtract, i.e. Y inverted with carry-in 1
- cmd_chain  in  1  use previous result as X (see Configuration)
- alu_x  out  4  registered X to ALU
- alu_y  out  4  registered Y to ALU
- alu_s  out  2  registered {S1,S0} to ALU
- alu_m0  out  1  registered M0 to ALU
- alu_f  in  4  ALU result F
- alu_flags  in  4  ALU {sign, zero, overflow, carryOut}
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_f  out  4  captured F
- rsp_flags  out  4  captured flags
- rsp_tag  out  8  value of op_count at capture
- op_count  out  8  completed responses, wraps 255→0

## Operation
- FIFO push on cmd_valid && cmd_ready. cmd_ready = !full, registered state only, with no combinational path from the pop side. There is no bypass: a command pushed into an empty FIFO is popped no earlier than the next edge.
- FSM states:
  - IDLE: when the FIFO is non-empty, pop the head, load alu_* registers, clear the settle counter, go to WAIT.
  - WAIT: count SETTLE_CYCLES edges. On the last one, sample alu_f and alu_flags into rsp_f and rsp_flags, set rsp_tag = op_count, set rsp_valid, go to RESP.
  - RESP: hold rsp_* stable while rsp_valid && !rsp_ready. On handshake:
    - clear rsp_valid and increment op_count;
    - if the FIFO is non-empty, pop and load alu_* in the same edge and go to WAIT;
    - otherwise go to IDLE.
- alu_* outputs hold their last values in IDLE and RESP; they are not cleared.
- Responses are returned strictly in command order. Exactly one command is in flight outside the FIFO.
- Reset (asynchronous, any state):
  - FIFO emptied, FSM to IDLE;
  - alu_*, rsp_*, rsp_valid and op_count forced to 0;
  - cmd_ready = 1;
  - any in-flight command is discarded with no response.

## Timing
- Latency: command accepted at edge k into an empty FIFO, FSM in IDLE.
  - Edge k+1: pop, alu_* valid.
  - Edge k+1+SETTLE_CYCLES: capture, rsp_valid high.
- Sustained throughput with rsp_ready held 1: one response per SETTLE_CYCLES+1 cycles.
- Capacity with rsp_ready held 0: FIFO_DEPTH+1 commands accepted (one in flight) before cmd_ready drops.
- A push and a pop in the same edge on a full FIFO cannot occur, because cmd_ready is already 0. The push is refused and the pop proceeds.
- op_count 255 plus one handshake gives 0. rsp_tag carries the pre-increment value.

## Configuration
- ALU_SEQ_CHAIN_EN defined:
  - when a popped command has cmd_chain = 1, alu_x loads the last captured rsp_f instead of cmd_x;
  - the last captured rsp_f is 0 after reset;
  - cmd_chain is stored in the FIFO entry.
- ALU_SEQ_CHAIN_EN undefined:
  - cmd_chain is ignored and not stored;
  - alu_x always equals cmd_x;
  - the port remains present.

## Test plan
All scenarios bench the block against a behavioural model of the ALU.
- ADD: X=5, Y=3, op=00, M0=0 → rsp_f=8, rsp_flags=1010, rsp_tag=0; rsp_valid high exactly SETTLE_CYCLES+1 edges after acceptance.
- SUB: X=3, Y=3, op=00, M0=1 → rsp_f=0, rsp_flags=0100. Then XOR: X=A, Y=5, op=11 → rsp_f=F, rsp_flags=1000, rsp_tag=1.
- Backpressure: rsp_ready=0, offer 8 commands back-to-back with FIFO_DEPTH=4 → cmd_ready drops after 5 accepts. After raising rsp_ready, 5 responses return in order, then op_count=5.
- Chain, ALU_SEQ_CHAIN_EN defined: 1+1, then chain with Y=1 (op 00, M0=0) → rsp_f values 2 then 3. With the macro undefined and the second command's cmd_x=7 → rsp_f=8.
- Reset mid-operation: assert RESET_N=0 during WAIT with 2 commands queued → outputs 0 immediately, cmd_ready=1, and no response is produced after release.
- Wrap: complete 256 operations → op_count=0, last rsp_tag=255.
